// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
//   Multi-cycle adder: two WIDTH-bit operands are added CHUNK bits per clock,
//   LSB chunk first, with a 1-bit registered carry between chunks. The sum is
//   shifted into S from the MSB end, so after WIDTH/CHUNK add cycles S holds
//   the LSB-aligned result. Handshake: start is accepted only while ready=1,
//   done pulses for one cycle when S/C_out/ovf become valid.
//
//   Optional feature macro: SERIAL_CHUNK_ADDER_SUB_EN
//     defined   : sub=1 at acceptance computes A - B (B inverted, carry-in 1)
//     undefined : sub is ignored, the block always computes A + B + C_in
//
//   Reset is synchronous, active-low.
// -----------------------------------------------------------------------------
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             ovf,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, s_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               c_out_reg, ovf_reg;

  // Combinational datapath signals
  logic [CHUNK:0]     chunk_sum;
  logic [CHUNK-1:0]   sum_chunk;
  logic               chunk_carry;
  logic               msb_carry_in;
  logic [WIDTH-1:0]   s_shifted;
  logic               last_chunk;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // Operand conditioning at acceptance: pass-through add, or invert-and-add-one subtract.
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  always_comb begin
    b_load     = sub ? ~B   : B;
    carry_load = sub ? 1'b1 : C_in;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  always_comb begin
    b_load     = B;
    carry_load = C_in;
  end
`endif

  // One chunk of addition plus the shifted sum and the last-chunk flag.
  always_comb begin
    // NOTE: every output of an always_comb gets a value before any branch, so no path can leave one unassigned and infer a latch.
    chunk_sum    = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + (CHUNK+1)'(carry);
    sum_chunk    = chunk_sum[CHUNK-1:0];
    chunk_carry  = chunk_sum[CHUNK];
    // Carry into the chunk's top bit, recovered from that bit's sum and inputs.
    msb_carry_in = sum_chunk[CHUNK-1] ^ a_reg[CHUNK-1] ^ b_reg[CHUNK-1];
    s_shifted    = s_reg >> CHUNK;
    s_shifted[WIDTH-1 -: CHUNK] = sum_chunk;
    last_chunk   = (cnt == CNT_W'(NCHUNK - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)      state_next = ST_RUN;
      ST_RUN:  if (last_chunk) state_next = ST_DONE;
      ST_DONE:                 state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= b_load;
            carry <= carry_load;
            s_reg <= '0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_reg <= a_reg >> CHUNK;
          b_reg <= b_reg >> CHUNK;
          s_reg <= s_shifted;
          carry <= chunk_carry;
          cnt   <= cnt + 1'b1;
          if (last_chunk) begin
            c_out_reg <= chunk_carry;
            ovf_reg   <= msb_carry_in ^ chunk_carry;
          end
        end
        default: ; // ST_DONE: results hold
      endcase
    end
  end

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);
  assign S     = s_reg;
  assign C_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_chunk_adder
//   Driver issues operations and pushes the expected response (from an
//   arithmetic reference model) into a scoreboard queue; a monitor pops and
//   compares whenever done is seen. Honours SERIAL_CHUNK_ADDER_SUB_EN.
// -----------------------------------------------------------------------------
module tb_serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);

  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    int               done_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             C_in, sub;
  logic             ready;
  logic [WIDTH-1:0] S;
  logic             C_out, ovf, done;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];

  serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .sub   (sub),
    .ready (ready),
    .S     (S),
    .C_out (C_out),
    .ovf   (ovf),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge is the index of the preceding rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic is_sub);
    exp_t   e;
    logic   do_sub;
    longint ua, ub, full, sa, sbv, sres, smax, smin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    do_sub = is_sub;
`else
    do_sub = 1'b0;
`endif
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (do_sub) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sres = sa - sbv;
    end else begin
      full = ua + ub + longint'(cin);
      e.c  = full[WIDTH];
      sres = sa + sbv + longint'(cin);
    end
    e.s        = full[WIDTH-1:0];
    e.v        = (sres > smax) || (sres < smin);
    e.done_cyc = 0;
    return e;
  endfunction

  // Wait (bounded) at negedges until the DUT is ready; returns whether it became ready.
  task automatic wait_ready(output bit ok);
    int guard = 0;
    while (ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    ok = (ready === 1'b1);
    if (!ok) check("ready_timeout", {63'd0, ready}, 64'd1);
  endtask

  // Issue one operation; optionally scramble inputs (including start) while busy.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic is_sub, input bit garble);
    bit   ok;
    int   accept;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    start  = 1'b1;
    A      = a;
    B      = b;
    C_in   = cin;
    sub    = is_sub;
    accept = cyc + 1;
    e          = model(a, b, cin, is_sub);
    e.done_cyc = accept + NCHUNK;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < accept + NCHUNK + 1) begin
      if (cyc == accept + NCHUNK) check("ready_low_in_done", {63'd0, ready}, 64'd0);
      if (garble) begin
        start = 1'($urandom_range(0, 1));
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        C_in  = 1'($urandom);
        sub   = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ready_return",  {63'd0, ready}, 64'd1);
    check("S_hold",        64'(S),         64'(e.s));
    check("C_out_hold",    {63'd0, C_out}, {63'd0, e.c});
    check("ovf_hold",      {63'd0, ovf},   {63'd0, e.v});
  endtask

  // Start an operation, then reset mid-run; no result may be produced.
  task automatic abort_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    start = 1'b1;
    A     = a;
    B     = b;
    C_in  = 1'b0;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (NCHUNK >= 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_done",  {63'd0, done},  64'd0);
    check("abort_S",     64'(S),         64'd0);
    check("abort_C_out", {63'd0, C_out}, 64'd0);
    check("abort_ovf",   {63'd0, ovf},   64'd0);
    rst_n = 1'b1;
    repeat (NCHUNK + 3) @(negedge clk);
    check("abort_idle", {63'd0, ready}, 64'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc),       64'(e.done_cyc));
        check("S",          64'(S),         64'(e.s));
        check("C_out",      {63'd0, C_out}, {63'd0, e.c});
        check("ovf",        {63'd0, ovf},   {63'd0, e.v});
      end
    end
  end

  // Global time limit.
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    C_in  = 1'b0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_S",     64'(S),         64'd0);
    check("rst_C_out", {63'd0, C_out}, 64'd0);
    check("rst_ovf",   {63'd0, ovf},   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b0, 1'b0);
    run_op(WIDTH'(16'hFFFF), WIDTH'(16'h0001), 1'b0, 1'b0, 1'b0);
    run_op(WIDTH'(16'hFFFF), WIDTH'(16'h0000), 1'b1, 1'b0, 1'b0);
    run_op(WIDTH'(16'h7FFF), WIDTH'(16'h0001), 1'b0, 1'b0, 1'b0);
    run_op(WIDTH'(16'h8000), WIDTH'(16'h8000), 1'b0, 1'b0, 1'b0);
    // Starts and operand changes while busy must be ignored
    run_op(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b0, 1'b1);
    // Reset mid-operation
    abort_op(WIDTH'(16'hABCD), WIDTH'(16'h1111));
    // Subtract requests (plain add when the feature is compiled out)
    run_op(WIDTH'(16'h0005), WIDTH'(16'h0007), 1'b0, 1'b1, 1'b0);
    run_op(WIDTH'(16'h0007), WIDTH'(16'h0005), 1'b0, 1'b1, 1'b0);
    run_op(WIDTH'(16'h8000), WIDTH'(16'h0001), 1'b1, 1'b1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
